// File: rtl/mer_power_accumulator_pkg.sv
// Shared definitions for the MER power accumulator: FSM encoding,
// fixed-point widths of the sample and power formats, accumulator sizing.
package mer_power_accumulator_pkg;

  // Width of a signed 1s17 sample.
  localparam int S1_17_WIDTH = 18;
  // Width of an unsigned 2u34 power value (square of a 1s17 sample).
  localparam int U2_34_WIDTH = 2 * S1_17_WIDTH;

  // Measurement FSM encoding.
  localparam logic [1:0] STATE_IDLE   = 2'b00;
  localparam logic [1:0] STATE_SETTLE = 2'b01;
  localparam logic [1:0] STATE_ACCUM  = 2'b10;
  localparam logic [1:0] STATE_FLUSH  = 2'b11;

  // Accumulator width that holds 2^log2_n full-scale squares without wrapping.
  function automatic int acc_width(input int data_width, input int log2_n);
    return 2 * data_width + log2_n;
  endfunction

endpackage

// File: rtl/mer_power_accumulator_power_accum.sv
// One power stream: registers sample^2 on a counted symbol, then adds it
// to a wide accumulator on the following clock. The mean is the
// accumulator divided by 2^LOG2_N (truncating).
module mer_power_accumulator_power_accum
  import mer_power_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = S1_17_WIDTH,
  parameter int LOG2_N     = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_en,
  input  logic                         sq_valid,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic [2*DATA_WIDTH-1:0]      mean
);

  localparam int SQ_W  = 2 * DATA_WIDTH;
  localparam int ACC_W = acc_width(DATA_WIDTH, LOG2_N);

  logic signed [SQ_W-1:0] sample_ext_s;
  logic signed [SQ_W-1:0] prod_s;
  logic [SQ_W-1:0]        sq_r;
  logic [ACC_W-1:0]       acc_r;

  // Square at full product width; (-2^(W-1))^2 is positive and fits.
  always_comb begin
    sample_ext_s = {{DATA_WIDTH{sample[DATA_WIDTH-1]}}, sample};
    prod_s       = sample_ext_s * sample_ext_s;
  end

  // Square register, loaded on each counted symbol.
  always_ff @(posedge clk) begin
    if (reset) begin
      sq_r <= '0;
    end else if (sample_en) begin
      sq_r <= $unsigned(prod_s);
    end else begin
      sq_r <= sq_r;
    end
  end

  // Accumulator: cleared by the FSM, adds one square per counted symbol.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
    end else if (sq_valid) begin
      acc_r <= acc_r + {{LOG2_N{1'b0}}, sq_r};
    end else begin
      acc_r <= acc_r;
    end
  end

  assign mean = acc_r[ACC_W-1:LOG2_N];

endmodule

// File: rtl/mer_power_accumulator.sv
// MER power accumulator: after a warm-up of SETTLE_SYMBOLS symbols, averages
// error^2 and reference^2 over 2^LOG2_N symbols and reports both means with
// a one-clock result_valid pulse. Supports one-shot and continuous runs.
module mer_power_accumulator
  import mer_power_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH     = S1_17_WIDTH,
  parameter int LOG2_N         = 14,
  parameter int SETTLE_SYMBOLS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         start,
  input  logic                         continuous,
  input  logic signed [DATA_WIDTH-1:0] error,
  input  logic signed [DATA_WIDTH-1:0] errorless_decision_variable,
  output logic [2*DATA_WIDTH-1:0]      avg_error_power,
  output logic [2*DATA_WIDTH-1:0]      avg_signal_power,
  output logic                         result_valid,
  output logic                         busy
);

  localparam int SETTLE_W = (SETTLE_SYMBOLS > 1) ? $clog2(SETTLE_SYMBOLS) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_SYMBOLS - 1);

  logic [1:0]              state_r;
  logic [1:0]              state_nxt_s;
  logic [SETTLE_W-1:0]     settle_cnt_r;
  logic [LOG2_N-1:0]       sample_cnt_r;
  logic                    flush_cnt_r;
  logic                    sq_valid_r;
  logic                    sample_en_s;
  logic                    flush_done_s;
  logic                    clear_s;
  logic [2*DATA_WIDTH-1:0] err_mean_s;
  logic [2*DATA_WIDTH-1:0] sig_mean_s;

  // Next-state logic; also marks counted symbols (E0) in ACCUM.
  always_comb begin
    state_nxt_s = state_r;
    sample_en_s = 1'b0;
    case (state_r)
      STATE_IDLE: begin
        if (start) begin
          if (SETTLE_SYMBOLS == 32'd0) begin
            state_nxt_s = STATE_ACCUM;
          end else begin
            state_nxt_s = STATE_SETTLE;
          end
        end else begin
          state_nxt_s = STATE_IDLE;
        end
      end
      STATE_SETTLE: begin
        if (clk_en && (settle_cnt_r == SETTLE_LAST)) begin
          state_nxt_s = STATE_ACCUM;
        end else begin
          state_nxt_s = STATE_SETTLE;
        end
      end
      STATE_ACCUM: begin
        sample_en_s = clk_en;
        if (clk_en && (sample_cnt_r == '1)) begin
          state_nxt_s = STATE_FLUSH;
        end else begin
          state_nxt_s = STATE_ACCUM;
        end
      end
      STATE_FLUSH: begin
        // Second FLUSH clock is E2: last square has been added at E1.
        if (flush_cnt_r) begin
          if (continuous) begin
            state_nxt_s = STATE_ACCUM;
          end else begin
            state_nxt_s = STATE_IDLE;
          end
        end else begin
          state_nxt_s = STATE_FLUSH;
        end
      end
      default: begin
        state_nxt_s = STATE_IDLE;
      end
    endcase
  end

  assign flush_done_s = (state_r == STATE_FLUSH) && flush_cnt_r;
  assign clear_s      = (state_r == STATE_IDLE) || flush_done_s;

  // FSM state, symbol counters and the shared square-valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= STATE_IDLE;
      busy         <= 1'b0;
      settle_cnt_r <= '0;
      sample_cnt_r <= '0;
      flush_cnt_r  <= 1'b0;
      sq_valid_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy       <= (state_nxt_s != STATE_IDLE);
      sq_valid_r <= sample_en_s;

      if ((state_r == STATE_SETTLE) && clk_en) begin
        settle_cnt_r <= settle_cnt_r + SETTLE_W'(1);
      end else if (state_r == STATE_IDLE) begin
        settle_cnt_r <= '0;
      end else begin
        settle_cnt_r <= settle_cnt_r;
      end

      // Wraps to zero on the last counted symbol, ready for a continuous block.
      if (sample_en_s) begin
        sample_cnt_r <= sample_cnt_r + LOG2_N'(1);
      end else if (state_r == STATE_IDLE) begin
        sample_cnt_r <= '0;
      end else begin
        sample_cnt_r <= sample_cnt_r;
      end

      if (state_r == STATE_FLUSH) begin
        flush_cnt_r <= ~flush_cnt_r;
      end else begin
        flush_cnt_r <= 1'b0;
      end
    end
  end

  // Result registers: load both means and pulse result_valid at E2.
  always_ff @(posedge clk) begin
    if (reset) begin
      avg_error_power  <= '0;
      avg_signal_power <= '0;
      result_valid     <= 1'b0;
    end else begin
      result_valid <= flush_done_s;
      if (flush_done_s) begin
        avg_error_power  <= err_mean_s;
        avg_signal_power <= sig_mean_s;
      end else begin
        avg_error_power  <= avg_error_power;
        avg_signal_power <= avg_signal_power;
      end
    end
  end

  mer_power_accumulator_power_accum #(
    .DATA_WIDTH(DATA_WIDTH),
    .LOG2_N    (LOG2_N)
  ) u_error_power (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en_s),
    .sq_valid (sq_valid_r),
    .clear    (clear_s),
    .sample   (error),
    .mean     (err_mean_s)
  );

  mer_power_accumulator_power_accum #(
    .DATA_WIDTH(DATA_WIDTH),
    .LOG2_N    (LOG2_N)
  ) u_signal_power (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en_s),
    .sq_valid (sq_valid_r),
    .clear    (clear_s),
    .sample   (errorless_decision_variable),
    .mean     (sig_mean_s)
  );

endmodule

// File: tb/tb_mer_power_accumulator.sv
// Scoreboard bench for mer_power_accumulator (LOG2_N=4, 3 settle symbols,
// one clk_en every 16 clocks). Expected means are computed from the driven
// samples and queued; a negedge monitor pops them on result_valid.
module tb_mer_power_accumulator;

  localparam int DW     = 18;
  localparam int LN     = 4;
  localparam int NSYM   = 16;
  localparam int SETTLE = 3;

  logic clk = 1'b0;
  logic reset, clk_en, start, continuous;
  logic signed [DW-1:0] error, refv;
  logic [2*DW-1:0] avg_error_power, avg_signal_power;
  logic result_valid, busy;

  int tests_run = 0;
  int tests_failed = 0;
  int results_seen = 0;
  int cyc = 0;
  int last_e0 = 0;
  int n_counted = 0;
  longint sum_e, sum_s, last_exp_err, last_exp_sig;
  longint q_err[$];
  longint q_sig[$];
  bit rv_prev = 1'b0;

  always #20 clk = ~clk;

  mer_power_accumulator #(
    .DATA_WIDTH    (DW),
    .LOG2_N        (LN),
    .SETTLE_SYMBOLS(SETTLE)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .clk_en                     (clk_en),
    .start                      (start),
    .continuous                 (continuous),
    .error                      (error),
    .errorless_decision_variable(refv),
    .avg_error_power            (avg_error_power),
    .avg_signal_power           (avg_signal_power),
    .result_valid               (result_valid),
    .busy                       (busy)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor: compare each result pulse with the oldest expectation.
  always @(negedge clk) begin
    if (result_valid) begin
      results_seen++;
      check("result_expected", longint'(q_err.size() > 0), 1);
      check("rv_one_clk", longint'(rv_prev), 0);
      check("latency", cyc - last_e0, 2);
      if (q_err.size() > 0) begin
        last_exp_err = q_err.pop_front();
        last_exp_sig = q_sig.pop_front();
        check("avg_error_power", avg_error_power, last_exp_err);
        check("avg_signal_power", avg_signal_power, last_exp_sig);
      end
    end
    rv_prev = result_valid;
  end

  // One symbol slot of 16 clocks; poke keeps clk_en high one more clock
  // (which lands in FLUSH when sent as the final counted symbol).
  task automatic send_symbol(input longint e, input longint r, input bit poke);
    @(negedge clk);
    error  = DW'(e);
    refv   = DW'(r);
    clk_en = 1'b1;
    @(negedge clk);
    last_e0 = cyc;
    if (poke) begin
      error = 18'sh1ffff;
      refv  = 18'sh1ffff;
    end else begin
      clk_en = 1'b0;
    end
    @(negedge clk);
    clk_en = 1'b0;
    repeat (13) @(negedge clk);
  endtask

  // Counted symbol: model update, expectation pushed before the last sample.
  task automatic counted(input longint e, input longint r, input bit poke);
    sum_e += e * e;
    sum_s += r * r;
    n_counted++;
    if (n_counted == NSYM) begin
      q_err.push_back(sum_e >>> LN);
      q_sig.push_back(sum_s >>> LN);
      sum_e = 0;
      sum_s = 0;
      n_counted = 0;
    end
    send_symbol(e, r, poke);
  endtask

  task automatic begin_meas();
    sum_e = 0;
    sum_s = 0;
    n_counted = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 64 && results_seen < n; i++) @(negedge clk);
    check("result_count", results_seen, n);
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; start = 1'b0; continuous = 1'b0;
    error = '0; refv = '0;
    repeat (3) @(negedge clk);
    check("rst_avg_err", avg_error_power, 0);
    check("rst_avg_sig", avg_signal_power, 0);
    check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // Baseline: constant ref 65536, error 9268.
    begin_meas();
    repeat (SETTLE) send_symbol(9268, 65536, 1'b0);
    for (int k = 0; k < NSYM; k++) counted(9268, 65536, 1'b0);
    wait_results(1);
    check("busy_idle_t1", busy, 0);

    // Full-scale negative error; previous result must hold until replaced.
    begin_meas();
    check("hold_err", avg_error_power, last_exp_err);
    check("hold_sig", avg_signal_power, last_exp_sig);
    repeat (SETTLE) send_symbol(-131072, 65536, 1'b0);
    for (int k = 0; k < NSYM; k++) counted(-131072, 65536, 1'b0);
    wait_results(2);

    // Large settle data must be excluded; ramp gives truncated mean.
    begin_meas();
    repeat (SETTLE) send_symbol(100000, 100000, 1'b0);
    for (int k = 0; k < NSYM; k++) counted(k, k * 1000, 1'b0);
    wait_results(3);

    // Abort mid-measurement with a one-clock reset.
    begin_meas();
    repeat (SETTLE) send_symbol(9268, 65536, 1'b0);
    repeat (8) send_symbol(9268, 65536, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_avg_err", avg_error_power, 0);
    check("abort_avg_sig", avg_signal_power, 0);
    check("abort_busy", busy, 0);
    check("abort_rv", result_valid, 0);
    repeat (40) @(negedge clk);
    check("abort_no_result", results_seen, 3);
    begin_meas();
    repeat (SETTLE) send_symbol(9268, 65536, 1'b0);
    for (int k = 0; k < NSYM; k++) counted(9268, 65536, 1'b0);
    wait_results(4);

    // Continuous: two back-to-back blocks, second one without settle.
    continuous = 1'b1;
    begin_meas();
    repeat (SETTLE) send_symbol(1000, 65536, 1'b0);
    for (int k = 0; k < NSYM; k++) counted((k % 2 == 0) ? 1000 : -1000, 65536, 1'b0);
    for (int k = 0; k < NSYM; k++) begin
      counted((k % 2 == 0) ? 1000 : -1000, 65536, 1'b0);
      if (k == 0) continuous = 1'b0;
    end
    wait_results(6);
    check("busy_idle_cont", busy, 0);

    // start during ACCUM and clk_en during FLUSH are both ignored.
    begin_meas();
    repeat (SETTLE) send_symbol(9268, 65536, 1'b0);
    for (int k = 0; k < NSYM; k++) begin
      counted(9268, 65536, k == NSYM - 1);
      if (k == 4) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_accum", busy, 1);
      end
    end
    wait_results(7);
    check("busy_idle_t6", busy, 0);
    check("queue_drained", q_err.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mer_power_accumulator.md
Name: mer_power_accumulator

Overview:
- Consumes the error and errorless decision variable streams produced by the MER measurement DUT stage in the symbol-enable domain.
- Squares both streams and accumulates them over 2^LOG2_N symbols, after discarding SETTLE_SYMBOLS warm-up symbols.
- Outputs the average error power and the average signal power, with a one-clk valid pulse; MER is their ratio, formed in software or in a later stage.
- Supports one-shot and back-to-back (continuous) measurement.

Parameters:
- DATA_WIDTH, 18, width of the input samples (1s17).
- LOG2_N, 14, log2 of the number of symbols averaged per measurement.
- SETTLE_SYMBOLS, 8, number of clk_en symbols discarded after start, to flush upstream pipelines.

Ports:
- clk  in  1  system clock (25 MHz). One clock domain only.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- clk_en  in  1  symbol enable (1.5625 MHz); marks the cycle in which the inputs are valid.
- start  in  1  pulse; begins a measurement when the block is idle.
- continuous  in  1  level; when 1, a new measurement starts immediately after each result.
- error  in  DATA_WIDTH  signed 1s17 error sample.
- errorless_decision_variable  in  DATA_WIDTH  signed 1s17 reference sample.
- avg_error_power  out  2*DATA_WIDTH  unsigned 2u34 mean of error^2.
- avg_signal_power  out  2*DATA_WIDTH  unsigned 2u34 mean of reference^2.
- result_valid  out  1  one-clk pulse when both averages update.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - Counters, accumulators, square registers, avg_error_power, avg_signal_power, result_valid and busy all go to 0.
  - Reset takes effect from any state; a measurement in progress is abandoned and no result_valid is produced.
- FSM states: IDLE, SETTLE, ACCUM, FLUSH.
- IDLE:
  - start=1 -> SETTLE (or ACCUM directly if SETTLE_SYMBOLS=0).
  - Clears accumulators and counters.
- SETTLE:
  - Counts clk_en pulses and ignores their data.
  - After the SETTLE_SYMBOLS-th pulse -> ACCUM.
- ACCUM:
  - Each clk_en pulse is a counted sample.
  - At the edge of a counted cycle (E0), register err_sq = error*error and sig_sq = ref*ref. Each is unsigned, 2*DATA_WIDTH bits; (-2^17)^2 = 2^34 must fit.
  - sq_valid is set at E0.
  - At the next edge (E1), both accumulators add their square. Accumulator width is 2*DATA_WIDTH+LOG2_N; no saturation is needed or permitted.
  - After the 2^LOG2_N-th counted pulse -> FLUSH.
- FLUSH:
  - Lasts exactly 2 clks after the final E0.
  - At E2 = E0+2:
    - avg_* <= acc[2*DATA_WIDTH+LOG2_N-1 : LOG2_N], i.e. truncation, floor division by 2^LOG2_N.
    - result_valid = 1 for that one clk.
    - Accumulators clear.
  - Next state: continuous=1 -> ACCUM with no re-settle; otherwise -> IDLE.
- Ordering of events:
  - clk_en in FLUSH or IDLE is ignored.
  - start is ignored while busy.
  - start and continuous are sampled only in IDLE and at FLUSH exit.
- Hold behaviour: avg_* hold their values between results, and still hold after a later start until the next result.
- Input constraint on upstream: clk_en must be separated by at least 3 clks. The nominal 16:1 ratio satisfies this.
- Latency: result_valid is high in the clk cycle following E2 relative to the final sample.

Decomposition:
- Shared package holds:
  - the FSM state encoding (2 bits);
  - the 1s17 and 2u34 width constants;
  - the function accumulator width = 2*DATA_WIDTH+LOG2_N.
- One natural sub-module: power_accum. It performs the registered square plus accumulate for one stream and is instantiated twice (error, reference), sharing sq_valid/clear controls from the FSM.

Test Plan (DATA_WIDTH=18, LOG2_N=4, SETTLE_SYMBOLS=3, clk_en 1-in-16):
- Constant ref=65536, error=9268, one start -> one result_valid; avg_signal_power=4294967296, avg_error_power=85895824; busy drops after the pulse.
- error=-131072 constant -> avg_error_power=17179869184 (2^34, full-scale, no wrap).
- 3 settle symbols with error=100000, then error=k for k=0..15 -> avg_error_power=77 (1240/16 truncated); the settle data is excluded.
- Reset asserted for 1 clk after 8 counted symbols -> outputs 0, no result_valid; a fresh start then gives a correct result.
- continuous=1 with error alternating +1000/-1000 -> result_valid every 16 symbols, each reporting 1000000; the second block has no settle symbols.
- start pulsed during ACCUM, and clk_en pulsed during FLUSH -> both ignored; results unchanged from the baseline run.
